// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Adds two wide operands (NUM_WORDS words of DATA_WIDTH bits each) by
//   time-sharing a single DATA_WIDTH-bit ripple carry adder, one word per
//   clock cycle, starting from word 0.
//
//   Optional feature macro: MULTIWORD_ADD_SUB_EN
//     When defined, the sub_in port is added. When sub_in is 1 at accept, the
//     block computes a - b: the b words are inverted and the word-0 carry is
//     forced to 1. In that case carry_out = 1 means no borrow occurred.
//
//   Ports
//     clk        : single clock, rising edge
//     reset      : synchronous, active-high reset
//     sub_in     : (MULTIWORD_ADD_SUB_EN only) 1 = subtract, latched at accept
//     start_in   : request one wide addition; accepted only while ready_out=1
//     ready_out  : high in IDLE, when a start will be accepted
//     a_in, b_in : wide operands, word 0 at the LSBs
//     carry_in   : carry into word 0
//     sum_out    : registered wide result, written one word per ADD cycle
//     carry_out  : registered carry out of the top word
//     done_out   : one-cycle pulse marking sum_out/carry_out valid

module ripple_carry_adder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);
  logic [DATA_WIDTH:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[DATA_WIDTH];
endmodule

module multiword_add_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic                            sub_in,
`endif
  input  logic                            start_in,
  output logic                            ready_out,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] a_in,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] b_in,
  input  logic                            carry_in,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] sum_out,
  output logic                            carry_out,
  output logic                            done_out
);
  localparam int WIDE  = DATA_WIDTH * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  carry_r;
  logic [WIDE-1:0]       a_r;
  logic [WIDE-1:0]       b_r;
  logic [WIDE-1:0]       sum_r;
  logic                  carry_out_r;
  logic [31:0]           base_s;
  logic [DATA_WIDTH-1:0] a_word_s;
  logic [DATA_WIDTH-1:0] b_word_s;
  logic [DATA_WIDTH-1:0] b_add_s;
  logic [DATA_WIDTH-1:0] add_sum_s;
  logic                  add_cout_s;
`ifdef MULTIWORD_ADD_SUB_EN
  logic                  sub_r;
`endif

  // Select word k of the latched operands for the shared adder.
  assign base_s   = 32'(cnt_r) * 32'(DATA_WIDTH);
  assign a_word_s = a_r[base_s +: DATA_WIDTH];
  assign b_word_s = b_r[base_s +: DATA_WIDTH];

`ifdef MULTIWORD_ADD_SUB_EN
  // Subtraction is a + ~b + 1; the +1 comes from the forced word-0 carry.
  assign b_add_s = sub_r ? ~b_word_s : b_word_s;
`else
  assign b_add_s = b_word_s;
`endif

  ripple_carry_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_adder (
    .a   (a_word_s),
    .b   (b_add_s),
    .cin (carry_r),
    .sum (add_sum_s),
    .cout(add_cout_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; ADD ends after the last word is processed.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_in) begin
          state_s = ADD;
        end else begin
          state_s = IDLE;
        end
      end
      ADD: begin
        if (cnt_r == LAST_WORD) begin
          state_s = DONE;
        end else begin
          state_s = ADD;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    ready_out = 1'b0;
    done_out  = 1'b0;
    case (state_r)
      IDLE:    ready_out = 1'b1;
      DONE:    done_out  = 1'b1;
      default: begin
        ready_out = 1'b0;
        done_out  = 1'b0;
      end
    endcase
  end

  // Operand latch, word counter, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {WIDE{1'b0}};
      b_r         <= {WIDE{1'b0}};
      sum_r       <= {WIDE{1'b0}};
      carry_out_r <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_in) begin
            a_r   <= a_in;
            b_r   <= b_in;
            cnt_r <= {CNT_W{1'b0}};
`ifdef MULTIWORD_ADD_SUB_EN
            sub_r   <= sub_in;
            carry_r <= sub_in ? 1'b1 : carry_in;
`else
            carry_r <= carry_in;
`endif
          end
        end
        ADD: begin
          sum_r[base_s +: DATA_WIDTH] <= add_sum_s;
          carry_r                     <= add_cout_s;
          // Counter holds on the last word instead of wrapping.
          if (cnt_r == LAST_WORD) begin
            carry_out_r <= add_cout_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign sum_out   = sum_r;
  assign carry_out = carry_out_r;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (DATA_WIDTH=8, NUM_WORDS=4).
// The driver pushes the expected result of every accepted operation into a
// queue; the monitor pops and compares on each done_out pulse.
module tb_multiword_add_sequencer;
  localparam int DW  = 8;
  localparam int NW  = 4;
  localparam int W   = DW * NW;
  localparam int LAT = NW + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         sub_in;
  logic         start_in;
  logic         ready_out;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         done_out;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub_in   (sub_in),
`endif
    .start_in (start_in),
    .ready_out(ready_out),
    .a_in     (a_in),
    .b_in     (b_in),
    .carry_in (carry_in),
    .sum_out  (sum_out),
    .carry_out(carry_out),
    .done_out (done_out)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain wide arithmetic on the whole operand.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0] t;
    exp_t       e;
    if (sub) t = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    else     t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    return e;
  endfunction

  // Monitor: latency, busy ready_out, result compare and result hold in IDLE.
  int           neg_idx = 0;
  int           acc_idx = -1;
  int           hold_at = -1;
  logic [W-1:0] last_sum;
  logic         last_c;
  exp_t         got_e;

  always @(negedge clk) begin
    neg_idx++;
    if (reset) begin
      acc_idx = -1;
      hold_at = -1;
    end else begin
      if (acc_idx >= 0 && neg_idx > acc_idx && neg_idx <= acc_idx + LAT)
        check("ready_low_busy", 64'(ready_out), 64'd0);
      if (done_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done_out), 64'd0);
        end else begin
          got_e = exp_q.pop_front();
          check("sum", 64'(sum_out), 64'(got_e.sum));
          check("carry_out", 64'(carry_out), 64'(got_e.cout));
          if (acc_idx >= 0) check("latency", 64'(neg_idx - acc_idx), 64'(LAT));
          last_sum = got_e.sum;
          last_c   = got_e.cout;
          hold_at  = neg_idx + 1;
          acc_idx  = -1;
        end
      end
      if (hold_at == neg_idx) begin
        check("ready_after_done", 64'(ready_out), 64'd1);
        check("sum_hold", 64'(sum_out), 64'(last_sum));
        check("carry_hold", 64'(carry_out), 64'(last_c));
      end
      if (start_in && ready_out) acc_idx = neg_idx;
    end
  end

  task automatic scramble();
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    carry_in = 1'($urandom);
  endtask

  // Wait (bounded) until every expected result has been seen, then settle.
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    a_in     = a;
    b_in     = b;
    carry_in = cin;
    sub_in   = sub;
    start_in = 1'b1;
    exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #2;
    start_in = 1'b0;
    scramble();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic sub_r;
    reset    = 1'b1;
    start_in = 1'b0;
    sub_in   = 1'b0;
    a_in     = '0;
    b_in     = '0;
    carry_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(ready_out), 64'd1);
    check("reset_done", 64'(done_out), 64'd0);
    check("reset_sum", 64'(sum_out), 64'd0);
    check("reset_carry", 64'(carry_out), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;

    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      sub_r = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_r = 1'($urandom);
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom), sub_r);
    end

    // start_in held high with operands churning while busy.
    sub_in = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); carry_in = 1'($urandom);
    start_in = 1'b1;
    exp_q.push_back(model(a_in, b_in, carry_in, 1'b0));
    @(posedge clk);
    #2;
    repeat (LAT) begin
      scramble();
      @(posedge clk);
      #2;
    end
    scramble();
    exp_q.push_back(model(a_in, b_in, carry_in, 1'b0));
    @(posedge clk);
    #2;
    start_in = 1'b0;
    wait_idle();

    // Reset during the third ADD cycle aborts the operation.
    a_in = 32'hDEAD_BEEF; b_in = 32'h0F0F_0F0F; carry_in = 1'b1;
    start_in = 1'b1;
    exp_q.push_back(model(a_in, b_in, carry_in, 1'b0));
    @(posedge clk);
    #2;
    start_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("abort_sum", 64'(sum_out), 64'd0);
    check("abort_carry", 64'(carry_out), 64'd0);
    check("abort_ready", 64'(ready_out), 64'd1);
    check("abort_done", 64'(done_out), 64'd0);
    repeat (10) @(posedge clk);
    #2;

    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

`ifdef MULTIWORD_ADD_SUB_EN
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of the single shared ripple carry adder (one word).
REQ-002 SHALL have parameter NUM_WORDS, default 4, meaning words per operand (legal range 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start_in, input, 1, request to begin one wide addition.
REQ-006 SHALL have port ready_out, output, 1, high when a start will be accepted.
REQ-007 SHALL have ports a_in and b_in, input, DATA_WIDTH*NUM_WORDS, wide operands, word 0 at LSBs.
REQ-008 SHALL have port carry_in, input, 1, carry into word 0.
REQ-009 SHALL have port sum_out, output, DATA_WIDTH*NUM_WORDS, registered wide result.
REQ-010 SHALL have port carry_out, output, 1, registered carry out of the top word.
REQ-011 SHALL have port done_out, output, 1, one-cycle pulse marking sum_out/carry_out valid.

Function
REQ-012 SHALL instantiate exactly one ripple_carry_adder (width DATA_WIDTH) and time-share it across all words; no other adder logic.
REQ-013 SHALL implement FSM states IDLE, ADD, DONE.
REQ-014 IDLE: ready_out=1; start_in=1 accepts; latches a_in, b_in, carry_in into internal registers, clears word counter, goes to ADD.
REQ-015 ADD: applies word k (k=counter) of latched operands plus carry register to adder; writes adder sum into sum_out word k, adder carry into carry register; counter increments.
REQ-016 ADD SHALL last exactly NUM_WORDS cycles; after word NUM_WORDS-1, carry_out takes final carry and FSM goes to DONE.
REQ-017 DONE: done_out=1 for exactly that cycle; next state IDLE unconditionally.
REQ-018 Latency: done_out high exactly NUM_WORDS+1 cycles after the accepting edge.
REQ-019 ready_out SHALL be 0 in ADD and DONE; start_in outside IDLE SHALL be ignored with no effect.
REQ-020 Input changes after acceptance SHALL not affect the in-flight result.
REQ-021 sum_out/carry_out SHALL hold their last result through IDLE until the next accepted start overwrites them word by word.
REQ-022 Counter width SHALL be ceil(log2(NUM_WORDS)); counter SHALL not wrap during ADD.

Reset
REQ-023 reset=1 SHALL force state IDLE, ready_out=1, done_out=0, sum_out=0, carry_out=0, counter=0, carry register=0.
REQ-024 reset asserted mid-ADD or in DONE SHALL abort the operation with no done_out pulse; reset has priority over start_in.

Configuration
REQ-025 Macro MULTIWORD_ADD_SUB_EN SHALL control subtraction support.
REQ-026 With MULTIWORD_ADD_SUB_EN defined: extra input sub_in (1 bit) latched at accept; when 1, adder receives inverted b words and word-0 carry is forced 1 (carry_in ignored), giving a-b with carry_out=1 meaning no borrow.
REQ-027 Without MULTIWORD_ADD_SUB_EN: no sub_in port; add-only behaviour per REQ-015.

Verification (DATA_WIDTH=8, NUM_WORDS=4)
REQ-028 a=0xFFFFFFFF, b=0x00000001, cin=0, start -> done_out 5 cycles later, sum=0x00000000, carry_out=1.
REQ-029 a=0x12345678, b=0x11111111, cin=1, start -> sum=0x2345678A, carry_out=0; ready_out low for 5 cycles.
REQ-030 start_in held high and operands changed during ADD -> single done_out, result from first accepted operands only; new acceptance on first IDLE cycle.
REQ-031 reset pulsed on 3rd ADD cycle -> no done_out, sum_out=0, carry_out=0, ready_out=1 next cycle.
REQ-032 With MULTIWORD_ADD_SUB_EN: a=0x00000005, b=0x00000007, sub_in=1 -> sum=0xFFFFFFFE, carry_out=0; a=7, b=5 -> sum=0x00000002, carry_out=1.
